// File: rtl/debounce_pkg.sv
// debounce_pkg: shared debounce constants for dual_debounce and its channels.
package debounce_pkg;
  localparam int DEBOUNCE_STABLE_CYCLES = 1000;
  localparam int DEBOUNCE_CNT_W = 16;
  localparam int DEBOUNCE_SIM_CYCLES = 4;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one-channel two-flop synchroniser, stability counter and edge pulses.
// DEBOUNCE_BYPASS_EN removes the counter so clean follows the synchronised input directly.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
  parameter int CNT_W = DEBOUNCE_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);
  logic sync1, sync2;
`ifdef DEBOUNCE_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      clean <= sync2;
      rise <= sync2 & ~clean;
      fall <= ~sync2 & clean;
    end
  end
`else
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == clean) cnt <= '0;
      else if (cnt == TERM) begin
        clean <= sync2;
        cnt <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else cnt <= cnt + 1'b1;
    end
  end
`endif
endmodule

// File: rtl/dual_debounce.sv
// dual_debounce: WIDTH independent debounced inputs with rise/fall pulses.
// Define DEBOUNCE_BYPASS_EN to skip debouncing for fast simulation.
module dual_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
  parameter int CNT_W = DEBOUNCE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .raw(raw_in[i]),
      .clean(clean_out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule

// File: tb/tb_dual_debounce.sv
// tb_dual_debounce: directed and random checks of dual_debounce against a sample-history model.
module tb_dual_debounce;
  import debounce_pkg::*;
  localparam int N = DEBOUNCE_SIM_CYCLES;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] clean_out, rise, fall;
  int tests = 0;
  int fails = 0;
  logic [1:0] hist [$];
  int run [2];
  logic [1:0] m_clean, m_rise, m_fall;
  int cnt_a, cnt_b;
  logic [1:0] v;

  dual_debounce #(.WIDTH(2), .STABLE_CYCLES(N), .CNT_W(DEBOUNCE_CNT_W)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .clean_out(clean_out), .rise(rise), .fall(fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // hist[1] is the raw value sampled two edges earlier, i.e. what the debouncer sees now
  task automatic step(input logic r, input logic [1:0] val);
    @(negedge clk);
    rst = r;
    raw_in = val;
    @(posedge clk);
    #1;
    m_rise = 2'b00;
    m_fall = 2'b00;
    if (r) begin
      hist = '{2'b00, 2'b00};
      run = '{0, 0};
      m_clean = 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (hist[1][c] != m_clean[c]) begin
          run[c]++;
          if (run[c] == N) begin
            m_clean[c] = hist[1][c];
            m_rise[c] = hist[1][c];
            m_fall[c] = ~hist[1][c];
            run[c] = 0;
          end
        end else run[c] = 0;
      end
      hist.pop_back();
      hist.push_front(val);
    end
    chk("clean", clean_out, m_clean);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("excl", rise & fall, 2'b00);
  endtask

  initial begin
    hist = '{2'b00, 2'b00};
    run = '{0, 0};
    m_clean = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11);
      chk("rst_clean", clean_out, 2'b00);
      chk("rst_pulse", rise | fall, 2'b00);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b11);
      chk("rst_rel", clean_out, i == 5 ? 2'b11 : 2'b00);
    end
    chk("rst_rel_rise", rise, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00);
    chk("to_zero", clean_out, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b01);
      chk("step_clean", clean_out, i == 5 ? 2'b01 : 2'b00);
      chk("step_rise", rise, i == 5 ? 2'b01 : 2'b00);
      chk("step_fall", fall, 2'b00);
    end
    step(1'b0, 2'b01);
    chk("step_one_shot", rise, 2'b00);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00);
    cnt_a = 0;
    for (int i = 0; i < 14; i++) begin
      v = (i < 4) ? 2'(i % 2) : 2'b01;
      step(1'b0, v);
      if (rise[0]) cnt_a++;
      chk("bounce_clean", clean_out, i == 8 ? 2'b01 : (i > 8 ? 2'b01 : 2'b00));
    end
    chk("bounce_rises", 2'(cnt_a), 2'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00);
    cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, i < 3 ? 2'b10 : 2'b00);
      if ((rise | fall) != 2'b00 || clean_out[1]) cnt_a++;
    end
    chk("glitch", 2'(cnt_a), 2'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b11);
    chk("both_high", clean_out, 2'b11);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b00);
      if (fall == 2'b11) cnt_a++;
      if (fall != 2'b00 && fall != 2'b11) cnt_b++;
    end
    chk("simul_fall", 2'(cnt_a), 2'd1);
    chk("simul_split", 2'(cnt_b), 2'd0);
    chk("simul_and", {1'b0, &clean_out}, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11);
    step(1'b1, 2'b11);
    chk("midrst_clean", clean_out, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b11);
      chk("midrst_rel", clean_out, i == 5 ? 2'b11 : 2'b00);
    end
    for (int i = 0; i < 60; i++) begin
      v = 2'($urandom_range(0, 3));
      cnt_a = $urandom_range(1, 2 * N + 2);
      for (int j = 0; j < cnt_a; j++) step($urandom_range(0, 99) == 0, v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
